// File: rtl/ll_tx_framer.sv
// ----------------------------------------------------------------------------
// ll_tx_framer: FWFT FIFO to Aurora LocalLink TX framer; optional per-frame sequence header via TX_SEQ_HEADER_EN
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ll_tx_framer #(
  parameter int DATA_W     = 16,
  parameter int PKT_LEN    = 64,
  parameter int IFG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              channel_up,
  input  logic              fifo_hold,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] tx_d,
  output logic              tx_sof_n,
  output logic              tx_eof_n,
  output logic              tx_src_rdy_n,
  input  logic              tx_dst_rdy_n,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        abort_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'(IFG_CYCLES - 1);
  localparam bit         HAS_GAP  = (IFG_CYCLES != 0);

  state_e      state_q, state_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;
  logic        xfer;
  logic        started;
  logic        link_ok;

`ifdef TX_SEQ_HEADER_EN
  logic        hdr_q, hdr_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] hdr_word;
  assign hdr_word = {8'hA5, seq_q};
`endif

  assign link_ok   = channel_up & ~fifo_hold;
  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= 8'd0;
      gap_cnt_q   <= 4'd0;
      frame_cnt_q <= 16'd0;
      abort_cnt_q <= 8'd0;
`ifdef TX_SEQ_HEADER_EN
      hdr_q       <= 1'b0;
      seq_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
`ifdef TX_SEQ_HEADER_EN
      hdr_q       <= hdr_d;
      seq_q       <= seq_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    fifo_rd_en   = 1'b0;
    tx_d         = '0;
    tx_sof_n     = 1'b1;
    tx_eof_n     = 1'b1;
    tx_src_rdy_n = 1'b1;
    xfer         = 1'b0;
    started      = 1'b0;
`ifdef TX_SEQ_HEADER_EN
    hdr_d        = hdr_q;
    seq_d        = seq_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (link_ok) begin
          state_d = S_SEND;
`ifdef TX_SEQ_HEADER_EN
          hdr_d   = 1'b1;
`endif
        end
      end

      S_SEND: begin
`ifdef TX_SEQ_HEADER_EN
        if (hdr_q) begin
          // Header is generated locally, so only the link state gates it.
          tx_src_rdy_n = ~channel_up;
          xfer         = channel_up & ~tx_dst_rdy_n;
          if (channel_up) begin
            tx_d     = DATA_W'(hdr_word);
            tx_sof_n = 1'b0;
          end
          if (!channel_up) begin
            state_d = S_IDLE;
            hdr_d   = 1'b0;
          end else if (xfer) begin
            hdr_d = 1'b0;
          end
        end else
`endif
        begin
          tx_src_rdy_n = ~link_ok;
          xfer         = link_ok & ~tx_dst_rdy_n;
          fifo_rd_en   = xfer;
          if (link_ok) begin
            tx_d     = fifo_dout;
`ifndef TX_SEQ_HEADER_EN
            tx_sof_n = ~(word_cnt_q == 8'd0);
`endif
            tx_eof_n = ~(word_cnt_q == LAST_IDX);
          end
`ifdef TX_SEQ_HEADER_EN
          started = 1'b1;
`else
          started = (word_cnt_q != 8'd0);
`endif
          if (!channel_up) begin
            if (started && abort_cnt_q != 8'hFF) begin
              abort_cnt_d = abort_cnt_q + 8'd1;
            end
            // Words already popped must be matched by a drain to keep packet alignment.
            state_d = (word_cnt_q != 8'd0) ? S_DRAIN : S_IDLE;
          end else if (xfer) begin
            if (word_cnt_q == LAST_IDX) begin
              word_cnt_d  = 8'd0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              gap_cnt_d   = 4'd0;
              state_d     = HAS_GAP ? S_GAP : S_IDLE;
`ifdef TX_SEQ_HEADER_EN
              seq_d       = seq_q + 8'd1;
`endif
            end else begin
              word_cnt_d = word_cnt_q + 8'd1;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 4'd0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      S_DRAIN: begin
        fifo_rd_en = ~fifo_hold;
        if (!fifo_hold) begin
          if (word_cnt_q == LAST_IDX) begin
            word_cnt_d = 8'd0;
            state_d    = S_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ll_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_ll_tx_framer: scoreboard bench for ll_tx_framer with an FWFT FIFO model
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ll_tx_framer;

  localparam int DATA_W     = 16;
  localparam int PKT_LEN    = 64;
  localparam int IFG_CYCLES = 4;
  localparam int BUDGET     = 3000;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              channel_up;
  logic              holdoff;
  logic              fifo_hold;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] tx_d;
  logic              tx_sof_n;
  logic              tx_eof_n;
  logic              tx_src_rdy_n;
  logic              tx_dst_rdy_n;
  logic [15:0]       frame_cnt;
  logic [7:0]        abort_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_xfer   = 0;
  int n_sof    = 0;
  int cyc      = 0;
  int last_eof_cyc = 0;
  int last_gap = 0;

  logic [15:0] fifo_mem[$];
  int          fifo_cnt = 0;
  bit          pend_pop = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          stall_q = 0;
  logic [17:0] held_q = '0;

  assign fifo_hold = holdoff | (fifo_cnt == 0);

  ll_tx_framer #(
    .DATA_W    (DATA_W),
    .PKT_LEN   (PKT_LEN),
    .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .channel_up  (channel_up),
    .fifo_hold   (fifo_hold),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .tx_d        (tx_d),
    .tx_sof_n    (tx_sof_n),
    .tx_eof_n    (tx_eof_n),
    .tx_src_rdy_n(tx_src_rdy_n),
    .tx_dst_rdy_n(tx_dst_rdy_n),
    .frame_cnt   (frame_cnt),
    .abort_cnt   (abort_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // FWFT FIFO model: the pop decided before the edge takes effect 1 time unit after it.
  always @(posedge clk) begin
    logic [15:0] dummy;
    #1;
    if (pend_pop && fifo_mem.size() > 0) dummy = fifo_mem.pop_front();
    pend_pop  = 0;
    fifo_cnt  = fifo_mem.size();
    fifo_dout = (fifo_cnt > 0) ? fifo_mem[0] : 16'h0;
  end

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      pend_pop = fifo_rd_en;
      if (fifo_rd_en) n_pops++;
      if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
        n_xfer++;
        if (!tx_sof_n) begin
          n_sof++;
          last_gap = cyc - last_eof_cyc - 1;
        end
        if (!tx_eof_n) last_eof_cyc = cyc;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL xfer_unexpected: got d=%h sof_n=%b eof_n=%b, required no transfer",
                   tx_d, tx_sof_n, tx_eof_n);
        end else begin
          mon_e = exp_q.pop_front();
          if ({tx_d, tx_sof_n, tx_eof_n} !== {mon_e.d, ~mon_e.sof, ~mon_e.eof}) begin
            n_fail++;
            $display("FAIL xfer_word: got d=%h sof_n=%b eof_n=%b, required d=%h sof_n=%b eof_n=%b",
                     tx_d, tx_sof_n, tx_eof_n, mon_e.d, ~mon_e.sof, ~mon_e.eof);
          end
        end
      end
      if (tx_src_rdy_n) begin
        n_assert++;
        if ({tx_d, tx_sof_n, tx_eof_n} !== {16'h0, 2'b11}) begin
          n_fail++;
          $display("FAIL idle_outputs: got d=%h sof_n=%b eof_n=%b, required d=0000 sof_n=1 eof_n=1",
                   tx_d, tx_sof_n, tx_eof_n);
        end
      end
      if (stall_q && !tx_src_rdy_n) begin
        n_assert++;
        if ({tx_d, tx_sof_n, tx_eof_n} !== held_q) begin
          n_fail++;
          $display("FAIL stall_stable: got %h, required %h", {tx_d, tx_sof_n, tx_eof_n}, held_q);
        end
      end
      stall_q = !tx_src_rdy_n && tx_dst_rdy_n;
      held_q  = {tx_d, tx_sof_n, tx_eof_n};
    end else begin
      pend_pop = 0;
      stall_q  = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] data_of(input int k);
    return 16'((k * 37) + 256);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fifo_load(input int k0, input int n);
    for (int i = 0; i < n; i++) fifo_mem.push_back(data_of(k0 + i));
    fifo_cnt  = fifo_mem.size();
    fifo_dout = fifo_mem[0];
  endtask

  task automatic exp_words(input int k0, input int n, input int idx0, input bit with_sof);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d   = data_of(k0 + i);
      e.sof = with_sof && ((idx0 + i) == 0);
      e.eof = (idx0 + i) == (PKT_LEN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(output int left);
    int t = 0;
    while ((exp_q.size() != 0 || fifo_cnt != 0) && t < BUDGET) begin
      step();
      t++;
    end
    left = exp_q.size() + fifo_cnt;
    repeat (IFG_CYCLES + 4) step();
  endtask

  task automatic wait_exp_empty(output int left);
    int t = 0;
    while (exp_q.size() != 0 && t < BUDGET) begin
      step();
      t++;
    end
    left = exp_q.size();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    channel_up   = 1'b1;
    holdoff      = 1'b1;
    tx_dst_rdy_n = 1'b0;
    fifo_dout    = 16'h0;
    #3;
    n_assert++;
    if ({fifo_rd_en, tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_d} !== {4'b0111, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b src_n=%b sof_n=%b eof_n=%b d=%h, required 0 1 1 1 0000",
               fifo_rd_en, tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_d);
    end
    n_assert++;
    if ({frame_cnt, abort_cnt} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got frame=%0d abort=%0d, required 0 0", frame_cnt, abort_cnt);
    end
    fifo_load(0, 64);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_assert++;
      if (tx_src_rdy_n !== 1'b1 || fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL holdoff_quiet: cycle %0d got src_n=%b rd=%b, required 1 0", c, tx_src_rdy_n, fifo_rd_en);
      end
    end
  endtask

  task automatic test_basic_frame();
    int left;
    int sof0 = n_sof;
    exp_words(0, 64, 0, 1'b1);
    step();
    holdoff = 1'b0;
    wait_done(left);
    n_assert++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL basic_done: got %0d words outstanding, required 0", left);
    end
    n_assert++;
    if (frame_cnt !== 16'd1 || (n_sof - sof0) !== 1) begin
      n_fail++;
      $display("FAIL basic_counts: got frame_cnt=%0d sofs=%0d, required 1 1", frame_cnt, n_sof - sof0);
    end
  endtask

  task automatic test_ifg();
    int left;
    fifo_load(64, 128);
    exp_words(64, 64, 0, 1'b1);
    exp_words(128, 64, 0, 1'b1);
    wait_done(left);
    n_assert++;
    if (left !== 0 || frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL ifg_frames: got left=%0d frame_cnt=%0d, required 0 3", left, frame_cnt);
    end
    n_assert++;
    if (last_gap < IFG_CYCLES || last_gap > IFG_CYCLES + 2) begin
      n_fail++;
      $display("FAIL ifg_gap: got %0d idle cycles, required %0d..%0d", last_gap, IFG_CYCLES, IFG_CYCLES + 2);
    end
  endtask

  task automatic test_back_pressure();
    int t = 0;
    int pops0 = n_pops;
    fifo_load(192, 64);
    exp_words(192, 64, 0, 1'b1);
    while ((exp_q.size() != 0 || fifo_cnt != 0) && t < BUDGET) begin
      step();
      tx_dst_rdy_n = ~tx_dst_rdy_n;
      t++;
    end
    tx_dst_rdy_n = 1'b0;
    repeat (IFG_CYCLES + 4) step();
    n_assert++;
    if ((n_pops - pops0) !== 64 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_pops: got pops=%0d outstanding=%0d, required 64 0", n_pops - pops0, exp_q.size());
    end
    n_assert++;
    if (frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_frame_cnt: got %0d, required 4", frame_cnt);
    end
  endtask

  task automatic test_underflow();
    int t = 0;
    int left;
    int sof0 = n_sof;
    fifo_load(256, 11);
    exp_words(256, 64, 0, 1'b1);
    while (fifo_cnt != 0 && t < BUDGET) begin
      step();
      t++;
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_assert++;
      if (tx_src_rdy_n !== 1'b1) begin
        n_fail++;
        $display("FAIL underflow_pause: cycle %0d got src_n=%b, required 1", c, tx_src_rdy_n);
      end
    end
    step();
    fifo_load(267, 53);
    wait_done(left);
    n_assert++;
    if (left !== 0 || frame_cnt !== 16'd5 || (n_sof - sof0) !== 1) begin
      n_fail++;
      $display("FAIL underflow_frame: got left=%0d frame_cnt=%0d sofs=%0d, required 0 5 1",
               left, frame_cnt, n_sof - sof0);
    end
  endtask

  task automatic test_abort();
    int left;
    int t = 0;
    int pops0;
    int xfer0;
    fifo_load(320, 128);
    exp_words(320, 20, 0, 1'b1);
    wait_exp_empty(left);
    channel_up = 1'b0;
    pops0 = n_pops;
    xfer0 = n_xfer;
    exp_words(384, 64, 0, 1'b1);
    while (fifo_cnt > 64 && t < BUDGET) begin
      step();
      t++;
      if (t == 3) channel_up = 1'b1;
    end
    channel_up = 1'b1;
    n_assert++;
    if ((n_pops - pops0) !== 44 || (n_xfer - xfer0) !== 0) begin
      n_fail++;
      $display("FAIL abort_drain: got pops=%0d xfers=%0d, required 44 0", n_pops - pops0, n_xfer - xfer0);
    end
    n_assert++;
    if (abort_cnt !== 8'd1 || frame_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL abort_counts: got abort=%0d frame=%0d, required 1 5", abort_cnt, frame_cnt);
    end
    wait_done(left);
    n_assert++;
    if (left !== 0 || frame_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL abort_resume: got left=%0d frame_cnt=%0d, required 0 6", left, frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int left;
    fifo_load(448, 64);
    exp_words(448, 30, 0, 1'b1);
    wait_exp_empty(left);
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({fifo_rd_en, tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_d} !== {4'b0111, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rd=%b src_n=%b sof_n=%b eof_n=%b d=%h, required 0 1 1 1 0000",
               fifo_rd_en, tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_d);
    end
    n_assert++;
    if (left !== 0 || {frame_cnt, abort_cnt} !== 24'h0) begin
      n_fail++;
      $display("FAIL midreset_counters: got left=%0d frame=%0d abort=%0d, required 0 0 0",
               left, frame_cnt, abort_cnt);
    end
    fifo_mem.delete();
    exp_q.delete();
    fifo_cnt  = 0;
    fifo_dout = 16'h0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

`ifdef TX_SEQ_HEADER_EN
  task automatic test_seq_header();
    int left;
    int x0 = n_xfer;
    exp_t e;
    for (int f = 0; f < 3; f++) begin
      e.d   = 16'hA500 | 16'(f);
      e.sof = 1'b1;
      e.eof = 1'b0;
      exp_q.push_back(e);
      exp_words(f * 64, 64, 0, 1'b0);
    end
    fifo_load(64, 128);
    step();
    holdoff = 1'b0;
    wait_done(left);
    n_assert++;
    if (left !== 0 || (n_xfer - x0) !== 195) begin
      n_fail++;
      $display("FAIL seq_header_xfers: got left=%0d xfers=%0d, required 0 195", left, n_xfer - x0);
    end
    n_assert++;
    if (frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL seq_header_frames: got %0d, required 3", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TX_SEQ_HEADER_EN
    test_seq_header();
`else
    test_basic_frame();
    test_ifg();
    test_back_pressure();
    test_underflow();
    test_abort();
    test_reset_midframe();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
